s4_fmap_buffer: RTL and testbench

S4_FMAP_BUFFER -- requirements
Module: s4_fmap_buffer

---
 rtl/s4_fmap_buffer.sv | 122 ++++++++++++
 tb/tb_s4_fmap_buffer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/s4_fmap_buffer.sv
// s4_fmap_buffer: frame buffer for the pooled S4 feature maps.
// The upstream layer fills the buffer word by word. A layer_fin pulse seals the
// frame, and a consumer then reads five lanes per cycle until consumer_done
// hands the buffer back for the next frame.
//
// Handshake semantics:
//   - A write is taken on any rising edge where wr_en=1. There is no backpressure.
//     In READY the write is refused and flagged in err_flags[0].
//   - A read request rd_en=1 in READY always succeeds.
//     rd_data_valid=1 on the following cycle marks rd_data_out_5P as the
//     result of that request.
//     When no read is served, rd_data_out_5P keeps its last value.
module s4_fmap_buffer #(
  parameter int DEPTH  = 400,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [31:0]           wr_addr_in,
  input  logic [DATA_W-1:0]     wr_data_in,
  input  logic                  layer_fin,
  input  logic                  rd_en,
  input  logic [5*32-1:0]       rd_addr_in_5P,
  input  logic                  consumer_done,
  output logic [5*DATA_W-1:0]   rd_data_out_5P,
  output logic                  rd_data_valid,
  output logic                  buf_ready,
  output logic [ADDR_W:0]       wr_count,
  output logic [2:0]            err_flags,
  output logic [1:0]            fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    READY = 2'd2
  } state_t;

  localparam logic [31:0]     DEPTH_A = 32'(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W:0]     count_inc;
  logic [ADDR_W:0]     count_nxt;
  logic [2:0]          err_nxt;
  logic                wr_in_range;
  logic                wr_accept;
  logic                rd_fire;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   lane_rd [5];

  assign wr_in_range = (wr_addr_in < DEPTH_A);
  assign wr_accept   = wr_en && wr_in_range && (state != READY);
  assign rd_fire     = (state == READY) && rd_en;
  assign count_inc   = (wr_accept && (wr_count != DEPTH_C)) ? wr_count + 1'b1 : wr_count;
  assign buf_ready   = (state == READY);
  assign fsm_state   = state;

  // Per-lane read mux. A lane pointing past the buffer reads as zero.
  for (genvar g = 0; g < 5; g++) begin : g_lane
    assign lane_rd[g] = (rd_addr_in_5P[32*g +: 32] < DEPTH_A)
                        ? mem[rd_addr_in_5P[32*g +: ADDR_W]] : '0;
  end

  // Next state, count and sticky error update. A write arriving with layer_fin is counted before the completeness check.
  always_comb begin
    state_nxt = state;
    count_nxt = count_inc;
    err_nxt   = err_flags;
    case (state)
      IDLE: begin
        if (wr_en && !wr_in_range) err_nxt[1] = 1'b1;
        if (wr_accept)             state_nxt  = FILL;
      end
      FILL: begin
        if (wr_en && !wr_in_range) err_nxt[1] = 1'b1;
        if (layer_fin) begin
          state_nxt = READY;
          if (count_inc != DEPTH_C) err_nxt[2] = 1'b1;
        end
      end
      READY: begin
        if (wr_en) err_nxt[0] = 1'b1;
        if (consumer_done) begin
          state_nxt = IDLE;
          count_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control and read-output registers. All of them clear on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      wr_count       <= '0;
      err_flags      <= '0;
      rd_data_valid  <= 1'b0;
      rd_data_out_5P <= '0;
    end else begin
      state         <= state_nxt;
      wr_count      <= count_nxt;
      err_flags     <= err_nxt;
      rd_data_valid <= rd_fire;
      if (rd_fire) begin
        for (int i = 0; i < 5; i++) begin
          rd_data_out_5P[DATA_W*i +: DATA_W] <= lane_rd[i];
        end
      end
    end
  end

  // Storage array. It has no reset, and its contents survive across frames.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_addr_in[ADDR_W-1:0]] <= wr_data_in;
  end

endmodule

// File: tb/tb_s4_fmap_buffer.sv
// Directed testbench for s4_fmap_buffer.
// Expected values are computed by hand from the fill patterns used below.
module tb_s4_fmap_buffer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr_en = 1'b0;
  logic [31:0]  wr_addr_in = '0;
  logic [15:0]  wr_data_in = '0;
  logic         layer_fin = 1'b0;
  logic         rd_en = 1'b0;
  logic [159:0] rd_addr_in_5P = '0;
  logic         consumer_done = 1'b0;
  logic [79:0]  rd_data_out_5P;
  logic         rd_data_valid;
  logic         buf_ready;
  logic [9:0]   wr_count;
  logic [2:0]   err_flags;
  logic [1:0]   fsm_state;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_READY = 2'd2;

  s4_fmap_buffer dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr_in(wr_addr_in),
    .wr_data_in(wr_data_in), .layer_fin(layer_fin), .rd_en(rd_en),
    .rd_addr_in_5P(rd_addr_in_5P), .consumer_done(consumer_done),
    .rd_data_out_5P(rd_data_out_5P), .rd_data_valid(rd_data_valid),
    .buf_ready(buf_ready), .wr_count(wr_count), .err_flags(err_flags),
    .fsm_state(fsm_state)
  );

  // Clock generation.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [15:0] data, input logic fin);
    wr_en      = 1'b1;
    wr_addr_in = addr;
    wr_data_in = data;
    layer_fin  = fin;
    tick();
    wr_en      = 1'b0;
    layer_fin  = 1'b0;
  endtask

  task automatic pulse_fin();
    layer_fin = 1'b1;
    tick();
    layer_fin = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                         input logic [31:0] a3, input logic [31:0] a4, input logic done);
    rd_en         = 1'b1;
    rd_addr_in_5P = {a4, a3, a2, a1, a0};
    consumer_done = done;
    tick();
    rd_en         = 1'b0;
    consumer_done = 1'b0;
  endtask

  function automatic logic [79:0] pack5(input logic [15:0] d0, input logic [15:0] d1,
                                        input logic [15:0] d2, input logic [15:0] d3,
                                        input logic [15:0] d4);
    return {d4, d3, d2, d1, d0};
  endfunction

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Directed sequence.
  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", 160'(fsm_state), 160'(S_IDLE));
    chk("rst_ready", 160'(buf_ready), 160'(0));
    chk("rst_count", 160'(wr_count), 160'(0));
    chk("rst_valid", 160'(rd_data_valid), 160'(0));
    chk("rst_data", 160'(rd_data_out_5P), 160'(0));
    chk("rst_err", 160'(err_flags), 160'(0));
    rst = 1'b0;
    tick();

    // Full frame with data k+1
    do_write(32'd0, 16'd1, 1'b0);
    chk("first_wr_state", 160'(fsm_state), 160'(S_FILL));
    chk("first_wr_count", 160'(wr_count), 160'(1));
    for (int k = 1; k < 400; k++) do_write(32'(k), 16'(k + 1), 1'b0);
    chk("fill_not_ready", 160'(buf_ready), 160'(0));
    chk("fill_count", 160'(wr_count), 160'(400));
    pulse_fin();
    chk("fin_ready", 160'(buf_ready), 160'(1));
    chk("fin_count", 160'(wr_count), 160'(400));
    chk("fin_err", 160'(err_flags), 160'(0));

    // Five-lane read including one out-of-range lane
    do_read(32'd0, 32'd24, 32'd25, 32'd399, 32'd400, 1'b0);
    chk("rd_valid", 160'(rd_data_valid), 160'(1));
    chk("rd_data", 160'(rd_data_out_5P), 160'(pack5(16'd1, 16'd25, 16'd26, 16'd400, 16'd0)));
    tick();
    chk("rd_idle_valid", 160'(rd_data_valid), 160'(0));
    chk("rd_hold_data", 160'(rd_data_out_5P), 160'(pack5(16'd1, 16'd25, 16'd26, 16'd400, 16'd0)));

    // A write in READY is refused, and layer_fin in READY is ignored
    do_write(32'd0, 16'hBEEF, 1'b0);
    chk("ready_wr_err", 160'(err_flags), 160'(3'b001));
    chk("ready_wr_count", 160'(wr_count), 160'(400));
    pulse_fin();
    chk("ready_fin_state", 160'(fsm_state), 160'(S_READY));
    chk("ready_fin_err", 160'(err_flags), 160'(3'b001));
    do_read(32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 1'b0);
    chk("ready_wr_nostore", 160'(rd_data_out_5P), 160'(pack5(16'd1, 16'd2, 16'd3, 16'd4, 16'd5)));

    // Read together with consumer_done
    do_read(32'd5, 32'd6, 32'd7, 32'd8, 32'd9, 1'b1);
    chk("done_valid", 160'(rd_data_valid), 160'(1));
    chk("done_data", 160'(rd_data_out_5P), 160'(pack5(16'd6, 16'd7, 16'd8, 16'd9, 16'd10)));
    chk("done_state", 160'(fsm_state), 160'(S_IDLE));
    chk("done_count", 160'(wr_count), 160'(0));
    chk("done_ready", 160'(buf_ready), 160'(0));
    do_read(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    chk("idle_rd_valid", 160'(rd_data_valid), 160'(0));
    pulse_fin();
    chk("idle_fin_state", 160'(fsm_state), 160'(S_IDLE));
    chk("idle_fin_err", 160'(err_flags), 160'(3'b001));

    // Frame A: 399 writes, an out-of-range write, then the last write with layer_fin
    reset_pulse();
    chk("rst2_err", 160'(err_flags), 160'(0));
    for (int k = 0; k < 399; k++) do_write(32'(k), 16'(k + 16'h1000), 1'b0);
    do_write(32'd400, 16'hDEAD, 1'b0);
    chk("oor_err", 160'(err_flags), 160'(3'b010));
    chk("oor_count", 160'(wr_count), 160'(399));
    do_write(32'd399, 16'h118F, 1'b1);
    chk("lastfin_state", 160'(fsm_state), 160'(S_READY));
    chk("lastfin_count", 160'(wr_count), 160'(400));
    chk("lastfin_err", 160'(err_flags), 160'(3'b010));
    do_read(32'd0, 32'd398, 32'd399, 32'd200, 32'hFFFF_FFFF, 1'b1);
    chk("frameA_data", 160'(rd_data_out_5P),
        160'(pack5(16'h1000, 16'h118E, 16'h118F, 16'h10C8, 16'd0)));
    do_write(32'd400, 16'h0, 1'b0);
    chk("idle_oor_state", 160'(fsm_state), 160'(S_IDLE));
    chk("idle_oor_count", 160'(wr_count), 160'(0));

    // Frame B: 398 writes including a duplicate address
    for (int k = 0; k < 397; k++) do_write(32'(k), 16'(k + 16'h2000), 1'b0);
    do_write(32'd0, 16'h7777, 1'b0);
    chk("dup_count", 160'(wr_count), 160'(398));
    pulse_fin();
    chk("short_state", 160'(fsm_state), 160'(S_READY));
    chk("short_err", 160'(err_flags), 160'(3'b110));
    do_read(32'd0, 32'd396, 32'd397, 32'd399, 32'd511, 1'b0);
    chk("frameB_data", 160'(rd_data_out_5P),
        160'(pack5(16'h7777, 16'h218C, 16'h118D, 16'h118F, 16'd0)));

    // Reset in the middle of a frame
    reset_pulse();
    for (int k = 0; k < 200; k++) do_write(32'(k), 16'(k + 1), 1'b0);
    chk("mid_count", 160'(wr_count), 160'(200));
    rst = 1'b1;
    #1;
    chk("async_state", 160'(fsm_state), 160'(S_IDLE));
    chk("async_count", 160'(wr_count), 160'(0));
    chk("async_valid", 160'(rd_data_valid), 160'(0));
    chk("async_data", 160'(rd_data_out_5P), 160'(0));
    chk("async_err", 160'(err_flags), 160'(0));
    tick();
    rst = 1'b0;
    for (int k = 0; k < 400; k++) do_write(32'(k), 16'(k + 1), 1'b0);
    do_write(32'd0, 16'd1, 1'b0);
    chk("sat_count", 160'(wr_count), 160'(400));
    pulse_fin();
    chk("refill_ready", 160'(buf_ready), 160'(1));
    chk("refill_count", 160'(wr_count), 160'(400));
    chk("refill_err", 160'(err_flags), 160'(0));
    do_read(32'd0, 32'd24, 32'd25, 32'd399, 32'd400, 1'b0);
    chk("refill_data", 160'(rd_data_out_5P), 160'(pack5(16'd1, 16'd25, 16'd26, 16'd400, 16'd0)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
